// File: rtl/cavlc_pkg.sv
// Shared CAVLC coeff_token types, lookup tables and nC -> table mapping.
// COEFF_TOKEN_CHROMA_DC_EN adds the chroma DC 4:2:0 table for nC = -1.
package cavlc_pkg;

    localparam int CT_LOOKUP_W = 16;
    localparam int CT_ENTRIES  = 68;   // 17 TotalCoeff values x 4 TrailingOnes values

    typedef enum logic [2:0] {
        TBL_0_2,
        TBL_2_4,
        TBL_4_8,
        TBL_FLC,
        TBL_CDC,
        TBL_ILL
    } table_sel_e;

    typedef struct packed {
        logic [4:0] TotalCoeff;
        logic [1:0] TrailingOnes;
        logic [4:0] CodeLen;
        logic       CodeErr;
    } coeff_token_t;

    typedef logic [4:0] ct_len_t  [CT_ENTRIES];
    typedef logic [3:0] ct_code_t [CT_ENTRIES];

    // Entry index = TotalCoeff*4 + TrailingOnes; length 0 marks an unused slot.
    localparam ct_len_t LEN_0_2 = '{
         1,  0,  0,  0,
         6,  2,  0,  0,
         8,  6,  3,  0,
         9,  8,  7,  5,
        10,  9,  8,  6,
        11, 10,  9,  7,
        13, 11, 10,  8,
        13, 13, 11,  9,
        13, 13, 13, 10,
        14, 14, 13, 11,
        14, 14, 14, 13,
        15, 15, 14, 14,
        15, 15, 15, 14,
        16, 15, 15, 15,
        16, 16, 16, 15,
        16, 16, 16, 16,
        16, 16, 16, 16
    };

    localparam ct_code_t CODE_0_2 = '{
         1,  0,  0,  0,
         5,  1,  0,  0,
         7,  4,  1,  0,
         7,  6,  5,  3,
         7,  6,  5,  3,
         7,  6,  5,  4,
        15,  6,  5,  4,
        11, 14,  5,  4,
         8, 10, 13,  4,
        15, 14,  9,  4,
        11, 10, 13, 12,
        15, 14,  9, 12,
        11, 10, 13,  8,
        15,  1,  9, 12,
        11, 14, 13,  8,
         7, 10,  9, 12,
         4,  6,  5,  8
    };

    localparam ct_len_t LEN_2_4 = '{
         2,  0,  0,  0,
         6,  2,  0,  0,
         6,  5,  3,  0,
         7,  6,  6,  4,
         8,  6,  6,  4,
         8,  7,  7,  5,
         9,  8,  8,  6,
        11,  9,  9,  6,
        11, 11, 11,  7,
        12, 11, 11,  9,
        12, 12, 12, 11,
        12, 12, 12, 11,
        13, 13, 13, 12,
        13, 13, 13, 13,
        13, 14, 13, 13,
        14, 14, 14, 13,
        14, 14, 14, 14
    };

    localparam ct_code_t CODE_2_4 = '{
         3,  0,  0,  0,
        11,  2,  0,  0,
         7,  7,  3,  0,
         7, 10,  9,  5,
         7,  6,  5,  4,
         4,  6,  5,  6,
         7,  6,  5,  8,
        15,  6,  5,  4,
        11, 14, 13,  4,
        15, 10,  9,  4,
        11, 14, 13, 12,
         8, 10,  9,  8,
        15, 14, 13, 12,
        11, 10,  9, 12,
         7, 11,  6,  8,
         9,  8, 10,  1,
         7,  6,  5,  4
    };

    localparam ct_len_t LEN_4_8 = '{
         4,  0,  0,  0,
         6,  4,  0,  0,
         6,  5,  4,  0,
         6,  5,  5,  4,
         7,  5,  5,  4,
         7,  5,  5,  4,
         7,  6,  6,  4,
         7,  6,  6,  4,
         8,  7,  7,  5,
         8,  8,  7,  6,
         9,  8,  8,  7,
         9,  9,  8,  8,
         9,  9,  9,  8,
        10,  9,  9,  9,
        10, 10, 10, 10,
        10, 10, 10, 10,
        10, 10, 10, 10
    };

    localparam ct_code_t CODE_4_8 = '{
        15,  0,  0,  0,
        15, 14,  0,  0,
        11, 15, 13,  0,
         8, 12, 14, 12,
        15, 10, 11, 11,
        11,  8,  9, 10,
         9, 14, 13,  9,
         8, 10,  9,  8,
        15, 14, 13, 13,
        11, 14, 10, 12,
        15, 10, 13, 12,
        11, 14,  9, 12,
         8, 10, 13,  8,
        13,  7,  9, 12,
         9, 12, 11, 10,
         5,  8,  7,  6,
         1,  4,  3,  2
    };

`ifdef COEFF_TOKEN_CHROMA_DC_EN
    // Chroma DC 4:2:0 only reaches TotalCoeff = 4.
    localparam ct_len_t LEN_CDC = '{
        0: 2,  4: 6,  5: 1,  8: 6,  9: 6, 10: 3,
        12: 6, 13: 7, 14: 7, 15: 6, 16: 6, 17: 8, 18: 8, 19: 7,
        default: 0
    };

    localparam ct_code_t CODE_CDC = '{
        0: 1,  4: 7,  5: 1,  8: 4,  9: 6, 10: 1,
        12: 3, 13: 3, 14: 2, 15: 5, 16: 2, 17: 3, 18: 2, 19: 0,
        default: 0
    };
`endif

    // Returns {len[4:0], code[3:0]} of one table entry.
    function automatic logic [8:0] ct_entry(table_sel_e sel, logic [6:0] idx);
        logic [8:0] e;
        e = '0;
        case (sel)
            TBL_0_2: e = {LEN_0_2[idx], CODE_0_2[idx]};
            TBL_2_4: e = {LEN_2_4[idx], CODE_2_4[idx]};
            TBL_4_8: e = {LEN_4_8[idx], CODE_4_8[idx]};
`ifdef COEFF_TOKEN_CHROMA_DC_EN
            TBL_CDC: e = {LEN_CDC[idx], CODE_CDC[idx]};
`endif
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic table_sel_e nc_to_table(logic signed [5:0] nc);
        table_sel_e t;
        if (nc == -6'sd1)
`ifdef COEFF_TOKEN_CHROMA_DC_EN
            t = TBL_CDC;
`else
            t = TBL_ILL;
`endif
        else if (nc < 6'sd0)
            t = TBL_ILL;
        else if (nc < 6'sd2)
            t = TBL_0_2;
        else if (nc < 6'sd4)
            t = TBL_2_4;
        else if (nc < 6'sd8)
            t = TBL_4_8;
        else
            t = TBL_FLC;
        return t;
    endfunction

endpackage

// File: rtl/coeff_token_match.sv
// Combinational coeff_token lookup: prefix match of the window MSBs against the selected table.
// Chroma DC entries exist only with COEFF_TOKEN_CHROMA_DC_EN (via cavlc_pkg).
module coeff_token_match
    import cavlc_pkg::*;
(
    input  table_sel_e             sel_i,
    input  logic [CT_LOOKUP_W-1:0] bits_i,
    output coeff_token_t           token_o
);

    logic [5:0] flc;
    logic [4:0] flc_tc;
    logic [8:0] ent;
    logic [4:0] sh;

    always_comb begin
        token_o         = '0;
        token_o.CodeErr = 1'b1;
        flc             = bits_i[CT_LOOKUP_W-1 -: 6];
        flc_tc          = {1'b0, flc[5:2]} + 5'd1;
        ent             = '0;
        sh              = '0;
        if (sel_i == TBL_FLC) begin
            if (flc == 6'b000011) begin
                token_o.CodeLen = 5'd6;
                token_o.CodeErr = 1'b0;
            end else if ({3'b000, flc[1:0]} <= flc_tc) begin
                token_o.TotalCoeff   = flc_tc;
                token_o.TrailingOnes = flc[1:0];
                token_o.CodeLen      = 5'd6;
                token_o.CodeErr      = 1'b0;
            end
        end else begin
            // Codes are prefix-free, so at most one entry can hit.
            for (int i = 0; i < CT_ENTRIES; i++) begin
                ent = ct_entry(sel_i, 7'(i));
                sh  = 5'(CT_LOOKUP_W) - ent[8:4];
                if (ent[8:4] != 5'd0 && (bits_i >> sh) == CT_LOOKUP_W'(ent[3:0])) begin
                    token_o.TotalCoeff   = 5'(i / 4);
                    token_o.TrailingOnes = 2'(i % 4);
                    token_o.CodeLen      = ent[8:4];
                    token_o.CodeErr      = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/coeff_token_decoder.sv
// Two-stage valid/ready CAVLC coeff_token decoder: S1 registers table select + window, S2 the token.
// Define COEFF_TOKEN_CHROMA_DC_EN to decode nC = -1 with the chroma DC table.
module coeff_token_decoder
    import cavlc_pkg::*;
#(
    parameter int BS_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [5:0]       nC,
    input  logic [BS_W-1:0]  BitStreamShifted,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [4:0]       TotalCoeff,
    output logic [1:0]       TrailingOnes,
    output logic [4:0]       CodeLen,
    output logic             CodeErr,
    output logic             ErrSticky,
    output logic [CNT_W-1:0] TokenCount
);

    if (BS_W < CT_LOOKUP_W) begin : g_bs_w_chk
        $error("coeff_token_decoder: BS_W must be >= 16");
    end

    localparam int STAGES = 2;

    logic [STAGES:1]        vld_pipe_q;
    table_sel_e             s1_sel_q;
    logic [CT_LOOKUP_W-1:0] s1_bits_q;
    coeff_token_t           lookup;
    coeff_token_t           out_q;
    logic                   err_sticky_q;
    logic [CNT_W-1:0]       tok_cnt_q, tok_cnt_d;
    logic                   s2_load, in_fire, out_fire;

    assign s2_load  = !vld_pipe_q[2] || OutReady;
    assign InReady  = !vld_pipe_q[1] || s2_load;
    assign in_fire  = InValid && InReady;
    assign out_fire = vld_pipe_q[2] && OutReady;

    coeff_token_match u_match (
        .sel_i   (s1_sel_q),
        .bits_i  (s1_bits_q),
        .token_o (lookup)
    );

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            vld_pipe_q <= '0;
            s1_sel_q   <= TBL_0_2;
            s1_bits_q  <= '0;
            out_q      <= '0;
        end else begin
            if (in_fire) begin
                vld_pipe_q[1] <= 1'b1;
                s1_sel_q      <= nc_to_table(nC);
                s1_bits_q     <= BitStreamShifted[BS_W-1 -: CT_LOOKUP_W];
            end else if (s2_load) begin
                vld_pipe_q[1] <= 1'b0;
            end
            // S2 only reloads when empty or being drained, so a stalled token stays put.
            if (s2_load) begin
                vld_pipe_q[2] <= vld_pipe_q[1];
                if (vld_pipe_q[1])
                    out_q <= lookup;
            end
        end
    end

    always_comb begin
        tok_cnt_d = tok_cnt_q;
        if (out_fire && !out_q.CodeErr && tok_cnt_q != '1)
            tok_cnt_d = tok_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            tok_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            tok_cnt_q <= tok_cnt_d;
            if (out_fire && out_q.CodeErr)
                err_sticky_q <= 1'b1;
        end
    end

    assign OutValid     = vld_pipe_q[2];
    assign TotalCoeff   = out_q.TotalCoeff;
    assign TrailingOnes = out_q.TrailingOnes;
    assign CodeLen      = out_q.CodeLen;
    assign CodeErr      = out_q.CodeErr;
    assign ErrSticky    = err_sticky_q;
    assign TokenCount   = tok_cnt_q;

endmodule

// File: tb/tb_coeff_token_decoder.sv
// Directed bench for coeff_token_decoder with hand-computed Table 9-5 expectations.
// Honours COEFF_TOKEN_CHROMA_DC_EN for the nC = -1 vectors.
module tb_coeff_token_decoder;

    logic        Clk = 1'b0;
    logic        nReset, InValid, InReady, OutValid, OutReady, CodeErr, ErrSticky;
    logic [5:0]  nC;
    logic [15:0] bs;
    logic [4:0]  tc, len;
    logic [1:0]  t1;
    logic [3:0]  tok_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int exp_sticky = 0;

    always #5 Clk = ~Clk;

    // Narrow counter so saturation is reachable.
    coeff_token_decoder #(.BS_W(16), .CNT_W(4)) dut (
        .Clk              (Clk),
        .nReset           (nReset),
        .InValid          (InValid),
        .InReady          (InReady),
        .nC               (nC),
        .BitStreamShifted (bs),
        .OutValid         (OutValid),
        .OutReady         (OutReady),
        .TotalCoeff       (tc),
        .TrailingOnes     (t1),
        .CodeLen          (len),
        .CodeErr          (CodeErr),
        .ErrSticky        (ErrSticky),
        .TokenCount       (tok_cnt)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cnt_inc();
        exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
    endtask

    task automatic run_one(input string tag, input logic [5:0] nc, input logic [15:0] bits,
                           input int etc, input int et1, input int elen, input int eerr);
        nC = nc; bs = bits; InValid = 1'b1; OutReady = 1'b1;
        check({tag, ".rdy"}, InReady, 1);
        @(posedge Clk); #1;
        InValid = 1'b0;
        check({tag, ".lat"}, OutValid, 0);
        @(posedge Clk); #1;
        check({tag, ".vld"}, OutValid, 1);
        check({tag, ".tc"},  tc,  etc);
        check({tag, ".t1"},  t1,  et1);
        check({tag, ".len"}, len, elen);
        check({tag, ".err"}, CodeErr, eerr);
        if (eerr != 0) exp_sticky = 1;
        else           cnt_inc();
        @(posedge Clk); #1;
        check({tag, ".drain"},  OutValid, 0);
        check({tag, ".cnt"},    tok_cnt, exp_cnt);
        check({tag, ".sticky"}, ErrSticky, exp_sticky);
    endtask

    task automatic do_reset(input string tag);
        nReset = 1'b0;
        #3;
        check({tag, ".rst_vld"}, OutValid, 0);
        nReset = 1'b1;
        exp_cnt = 0; exp_sticky = 0;
        @(posedge Clk); #1;
    endtask

    // mode 0: OutReady pattern 1,0,0 repeating; mode 1: always ready.
    task automatic burst(input string tag, input int mode, input int exp_last);
        int sent = 0, rcvd = 0, cyc = 0, last = -1;
        logic held_v = 1'b0;
        logic [12:0] held = '0;
        logic in_f, out_f;
        nC = 6'd9; InValid = 1'b1; bs = {4'd0, 2'b01, 10'd0};
        OutReady = 1'b1;
        while (rcvd < 8 && cyc < 100) begin
            @(negedge Clk);
            if (held_v) begin
                check({tag, ".hold_vld"}, OutValid, 1);
                check({tag, ".hold_dat"}, {tc, t1, len, CodeErr}, held);
            end
            in_f  = InValid && InReady;
            out_f = OutValid && OutReady;
            if (out_f) begin
                check({tag, ".tok"}, {tc, t1, len, CodeErr}, {5'(rcvd + 1), 2'd1, 5'd6, 1'b0});
                cnt_inc();
                rcvd++;
                last = cyc;
            end
            held_v = OutValid && !OutReady;
            held   = {tc, t1, len, CodeErr};
            @(posedge Clk); #1;
            if (in_f) sent++;
            InValid = (sent < 8);
            bs = {4'(sent), 2'b01, 10'd0};
            cyc++;
            OutReady = (mode == 1) || (cyc % 3 == 0);
        end
        InValid = 1'b0;
        check({tag, ".count"}, rcvd, 8);
        check({tag, ".last"}, last, exp_last);
        check({tag, ".tokcnt"}, tok_cnt, exp_cnt);
    endtask

    initial begin
        nReset = 1'b0; InValid = 1'b0; OutReady = 1'b0; nC = '0; bs = '0;
        #12;
        check("rst.vld", OutValid, 0);
        check("rst.tc", tc, 0);
        check("rst.t1", t1, 0);
        check("rst.len", len, 0);
        check("rst.err", CodeErr, 0);
        check("rst.sticky", ErrSticky, 0);
        check("rst.cnt", tok_cnt, 0);
        @(negedge Clk);
        nReset = 1'b1;
        @(posedge Clk); #1;

        run_one("n0_1",    6'd0,  16'h8000,  0, 0,  1, 0);
        run_one("n0_tc1",  6'd0,  16'h1400,  1, 0,  6, 0);
        run_one("n0_t1",   6'd0,  16'h4000,  1, 1,  2, 0);
        run_one("n1_tc2",  6'd1,  16'h2000,  2, 2,  3, 0);
        run_one("n0_max",  6'd0,  16'h0008, 16, 3, 16, 0);
        run_one("n1_l15",  6'd1,  16'h0002, 13, 1, 15, 0);
        run_one("n3",      6'd3,  16'hC000,  0, 0,  2, 0);
        run_one("n2",      6'd2,  16'h8000,  1, 1,  2, 0);
        run_one("n5",      6'd5,  16'hF000,  0, 0,  4, 0);
        run_one("n7",      6'd7,  16'hE000,  1, 1,  4, 0);
        run_one("n9",      6'd9,  16'h1000,  2, 0,  6, 0);
        run_one("n9_zero", 6'd9,  16'h0C00,  0, 0,  6, 0);
        run_one("n8_max",  6'd8,  16'hFC00, 16, 3,  6, 0);
        run_one("flc_bad", 6'd31, 16'h0800,  0, 0,  0, 1);
        run_one("n0_none", 6'd0,  16'h0000,  0, 0,  0, 1);
        run_one("n1_none", 6'd1,  16'h0001,  0, 0,  0, 1);
        run_one("nc_m2",   6'h3E, 16'h8000,  0, 0,  0, 1);
`ifdef COEFF_TOKEN_CHROMA_DC_EN
        run_one("cdc_01",  6'h3F, 16'h4000,  0, 0,  2, 0);
        run_one("cdc_1",   6'h3F, 16'h8000,  1, 1,  1, 0);
`else
        run_one("ncm1_ill", 6'h3F, 16'h4000, 0, 0,  0, 1);
`endif

        // Token in flight when reset hits must never surface.
        nC = 6'd0; bs = 16'h8000; InValid = 1'b1; OutReady = 1'b0;
        @(posedge Clk); #1;
        InValid = 1'b0;
        @(posedge Clk); #1;
        check("mid.vld_pre", OutValid, 1);
        do_reset("mid");
        for (int i = 0; i < 3; i++) begin
            check("mid.quiet", OutValid, 0);
            @(posedge Clk); #1;
        end
        check("mid.cnt", tok_cnt, 0);
        check("mid.sticky", ErrSticky, 0);

        burst("stall", 0, 24);
        check("stall.cnt8", tok_cnt, 8);
        burst("full", 1, 9);
        check("full.sat", tok_cnt, 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
